rrf: RTL

//  Retirement Register File: committed (architectural) areg->preg map for the
//  2-way OoO core. Applies up to 2 in-order commits per cycle from the ROB and

---
 rtl/rrf.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/rrf.sv
// rrf -- Retirement Register File.
//
// Holds the committed (architectural) areg->preg map of the 2-way OoO core.
// Up to two in-order commits per cycle update the map; every effective commit
// releases the areg's previously committed preg into a small in-order release
// FIFO that drains, one preg per cycle, to the free list.
//
// Optional feature macro: RRF_BYPASS_EN
//   defined   : when the FIFO is empty, the first release of the cycle is
//               presented on free_valid/free_preg combinationally and is not
//               enqueued if free_ready is high in the same cycle.
//   undefined : free_valid/free_preg come from FIFO state only.
//
// Ports
//   clk            clock, all state on posedge
//   rst            asynchronous active-high reset
//   commit_en      slot 0 commit valid (older)
//   commit_areg    slot 0 destination areg
//   commit_preg    slot 0 new committed preg
//   commit_en_1    slot 1 commit valid (younger)
//   commit_areg_1  slot 1 destination areg
//   commit_preg_1  slot 1 new committed preg
//   commit_ready   RRF can accept two commits this cycle
//   rrf_mapping    registered committed map, entry i = preg of areg i
//   free_valid     free_preg holds a preg for the free list
//   free_preg      preg being released
//   free_ready     free list accepts free_preg this cycle
//
// Handshakes: a commit slot is taken iff its enable and commit_ready are both
// high at the clock edge (slots presented while commit_ready is low are
// ignored and must be held by the ROB); a release is transferred iff
// free_valid and free_ready are both high at the clock edge.

module rrf #(
  parameter int NUM_PREGS = 64,
  parameter int REL_DEPTH = 4
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  commit_en,
  input  logic [4:0]                            commit_areg,
  input  logic [$clog2(NUM_PREGS)-1:0]          commit_preg,
  input  logic                                  commit_en_1,
  input  logic [4:0]                            commit_areg_1,
  input  logic [$clog2(NUM_PREGS)-1:0]          commit_preg_1,
  output logic                                  commit_ready,
  output logic [31:0][$clog2(NUM_PREGS)-1:0]    rrf_mapping,
  output logic                                  free_valid,
  output logic [$clog2(NUM_PREGS)-1:0]          free_preg,
  input  logic                                  free_ready
);

  localparam int PREG_W = $clog2(NUM_PREGS);
  localparam int PTR_W  = $clog2(REL_DEPTH);
  localparam int CNT_W  = $clog2(REL_DEPTH + 1);

  logic [31:0][PREG_W-1:0]        map_q, map_d;
  logic [REL_DEPTH-1:0][PREG_W-1:0] mem_q;
  logic [PTR_W-1:0]               wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]               count_q, count_d;

  logic              empty;
  logic              eff0, eff1;
  logic [PREG_W-1:0] rel0, rel1;
  logic [PREG_W-1:0] lst0, lst1;   // releases of this cycle, in program order
  logic [1:0]        n_rel;
  logic [PREG_W-1:0] enq0, enq1;   // releases actually written to the FIFO
  logic [1:0]        n_enq;
  logic              pop;
  logic [PTR_W-1:0]  wr_ptr_p1;

  assign empty        = (count_q == '0);
  assign commit_ready = (count_q <= CNT_W'(REL_DEPTH - 2));
  assign rrf_mapping  = map_q;

  assign eff0 = commit_en   && commit_ready && (commit_areg   != 5'd0);
  assign eff1 = commit_en_1 && commit_ready && (commit_areg_1 != 5'd0);

  // Same-areg pair: slot 1 retires the mapping slot 0 just installed.
  assign rel0 = map_q[commit_areg];
  assign rel1 = (eff0 && (commit_areg_1 == commit_areg)) ? commit_preg : map_q[commit_areg_1];

  always_comb begin
    lst0  = eff0 ? rel0 : rel1;
    lst1  = rel1;
    n_rel = {1'b0, eff0} + {1'b0, eff1};
  end

  always_comb begin
    map_d = map_q;
    if (eff0) map_d[commit_areg]   = commit_preg;
    if (eff1) map_d[commit_areg_1] = commit_preg_1;
  end

`ifdef RRF_BYPASS_EN
  logic byp_valid, byp_take;
  assign byp_valid  = empty && (n_rel != 2'd0);
  assign byp_take   = byp_valid && free_ready;
  assign free_valid = !empty || byp_valid;
  assign free_preg  = !empty ? mem_q[rd_ptr_q] : (byp_valid ? lst0 : '0);

  always_comb begin
    enq0  = byp_take ? lst1 : lst0;
    enq1  = lst1;
    n_enq = byp_take ? (n_rel - 2'd1) : n_rel;
  end
`else
  assign free_valid = !empty;
  assign free_preg  = empty ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    enq0  = lst0;
    enq1  = lst1;
    n_enq = n_rel;
  end
`endif

  // Only a queued entry is popped; a bypassed release never occupied the FIFO.
  assign pop       = !empty && free_ready;
  assign wr_ptr_p1 = wr_ptr_q + PTR_W'(1);

  always_comb begin
    wr_ptr_d = wr_ptr_q + PTR_W'(n_enq);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop);
    count_d  = count_q + CNT_W'(n_enq) - CNT_W'(pop);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) map_q[i] <= PREG_W'(i);
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      map_q    <= map_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (n_enq != 2'd0) mem_q[wr_ptr_q]  <= enq0;
      if (n_enq == 2'd2) mem_q[wr_ptr_p1] <= enq1;
    end
  end

endmodule
